serial_parity_detector: RTL and testbench
=========================================

// Module: serial_parity_detector
// PURPOSE
//   Running parity tracker for a one-bit serial stream, sampling one bit per clk rising edge.
//   Reports, through a registered 2-bit one-hot code, whether the count of 1s received
//   since reset (or frame start) is even or odd. Sits behind a serial input pin or
//   deserializer front end as a link-integrity monitor.
// PARAMETERS
//   FRAME_LEN  8  bits per parity frame; used only when SPD_FRAME_EN is defined; legal >= 1
// PORTS
//   clk  input  1  clock; all logic on rising edge
//   rst  input  1  synchronous, active-high reset
//   in   input  1  serial data bit; sampled every clk rising edge while rst=0
//   out  output 2  parity status: 2'b00 idle, 2'b10 even, 2'b01 odd; 2'b11 never driven
// BEHAVIOUR
//   - Single clock domain. Synchronous active-high reset: rst=1 at a clk edge -> state IDLE.
//     out=2'b00 on the following cycle. rst overrides any sample taken at that edge.
//   - FSM states: IDLE, EVEN, ODD. out is a registered Moore decode of the state:
//     IDLE->00, EVEN->10, ODD->01.
//   - Transitions on each edge with rst=0:
//     IDLE: in=0 -> EVEN; in=1 -> ODD.
//     EVEN: in=0 -> EVEN; in=1 -> ODD.
//     ODD:  in=0 -> ODD;  in=1 -> EVEN.
//   - Latency: out after edge N reflects the parity of all bits sampled at edges 1..N since reset.
//     This is one-cycle registered latency; there is no combinational path from in to out.
//   - No valid/ready handshake: every non-reset edge consumes one bit.
//   - X/Z on in is not masked. The state encoding must not let an unknown input create
//     out=2'b11 in a synthesised netlist.
//   - Unbounded stream (macro absent): parity accumulates indefinitely with no counter, so
//     there is no wrap-around.
//   - Reset mid-stream: the accumulated parity is discarded, and the next sample starts from IDLE.
// CONFIGURATION
//   SPD_FRAME_EN defined:
//     - A bit counter counts samples 0..FRAME_LEN-1.
//     - On the edge that samples bit FRAME_LEN-1, out shows the frame's final parity for one cycle.
//     - The next sample is treated as coming from IDLE, so the frame restarts. The counter
//       wraps to 0 at the same time.
//     - rst clears the counter.
//   SPD_FRAME_EN undefined:
//     - No counter and no frame restart. FRAME_LEN is ignored.
// STRUCTURE
//   - Package serial_parity_pkg holds:
//     - spd_state_t enum {IDLE, EVEN, ODD}
//     - localparams SPD_OUT_IDLE=2'b00, SPD_OUT_EVEN=2'b10, SPD_OUT_ODD=2'b01
//     - function spd_next(state, bit)
//   - Sub-module spd_frame_counter (clk, rst, advance, last) is instantiated only under
//     SPD_FRAME_EN. Its counter width is $clog2(FRAME_LEN) with a minimum of 1.
// TESTING
//   1. Reset: rst=1 for 2 cycles with in toggling -> out=2'b00 throughout and one cycle after release.
//   2. Stream 0,1,0,1,0 after reset -> out after each edge is 10,01,01,10,10.
//   3. Ten consecutive 1s -> out alternates 01,10,... and ends at 10.
//   4. Sequence 1,1,1, then rst on the next edge, then 0 -> out is 01,10,01,00,10.
//   5. Macro defined with FRAME_LEN=4, stream 1,0,0,0,1,1,0,0:
//      - out after each edge is 01,01,01,01,01,10,10,10.
//      - The frame boundary falls after the 4th bit.
//   6. Random stream of 1000 bits against a reference XOR model -> out matches every cycle;
//      2'b11 never appears.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: parity FSM states, output codes and next-state function
package serial_parity_pkg;
  localparam logic [1:0] SPD_OUT_IDLE = 2'b00;
  localparam logic [1:0] SPD_OUT_EVEN = 2'b10;
  localparam logic [1:0] SPD_OUT_ODD  = 2'b01;
  typedef enum logic [1:0] {
    IDLE = SPD_OUT_IDLE,
    EVEN = SPD_OUT_EVEN,
    ODD  = SPD_OUT_ODD
  } spd_state_t;
  function automatic spd_state_t spd_next(input spd_state_t s, input logic b);
    return ((s == ODD) ^ b) ? ODD : EVEN;
  endfunction
endpackage

// File: rtl/spd_frame_counter.sv
// spd_frame_counter: counts samples 0..FRAME_LEN-1, flags the last bit of each frame
// Ports: clk, rst (sync active-high), advance (count this edge), last (current sample ends frame)
module spd_frame_counter #(
  parameter int FRAME_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic last
);
  localparam int W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic [W-1:0] count;
  assign last = count == W'(FRAME_LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (advance) count <= last ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/serial_parity_detector.sv
// serial_parity_detector: running parity of a serial bit stream as a registered one-hot code
// Ports: clk, rst (sync active-high), in (serial bit), out (00 idle, 10 even, 01 odd)
// Macro SPD_FRAME_EN: restart parity every FRAME_LEN bits
module serial_parity_detector
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [1:0] out
);
  spd_state_t state, state_next, base;
  if (FRAME_LEN < 1) begin : g_bad_len
    $error("FRAME_LEN must be >= 1");
  end
`ifdef SPD_FRAME_EN
  logic last, restart;
  spd_frame_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt (
    .clk(clk),
    .rst(rst),
    .advance(1'b1),
    .last(last)
  );
  // restart marks that the previous sample closed a frame, so this one starts fresh
  always_ff @(posedge clk) begin
    if (rst) restart <= 1'b0;
    else restart <= last;
  end
  assign base = restart ? IDLE : state;
`else
  assign base = state;
`endif
  // state codes equal the output codes; the next state is always EVEN or ODD,
  // whose complementary bits cannot form 11 whatever value in takes
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = spd_next(base, in);
    out = state;
  end
endmodule

// File: tb/tb_serial_parity_detector.sv
// tb_serial_parity_detector: table-driven and random checks of serial_parity_detector
module tb_serial_parity_detector;
  localparam int FL = 4;
  typedef struct {
    logic       rst;
    logic       in;
    logic [1:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, in = 1'b0;
  logic [1:0] out;
  int checks = 0, failures = 0;
  vec_t vecs[$];
  serial_parity_detector #(.FRAME_LEN(FL)) dut (.clk(clk), .rst(rst), .in(in), .out(out));
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic i, input logic [1:0] e);
    vec_t v;
    v.rst = r; v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask
  task automatic step(input logic r, input logic i);
    @(negedge clk);
    rst = r;
    in = i;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: out=%b expected=%b", name, got, exp);
    end
  endtask
  initial begin
    logic ref_idle, ref_par, r, i, start;
    int cnt;
    logic [1:0] e;
    add(1, 0, 2'b00); add(1, 1, 2'b00);
`ifdef SPD_FRAME_EN
    add(0, 1, 2'b01); add(0, 0, 2'b01); add(0, 0, 2'b01); add(0, 0, 2'b01);
    add(0, 1, 2'b01); add(0, 1, 2'b10); add(0, 0, 2'b10); add(0, 0, 2'b10);
`else
    add(0, 0, 2'b10); add(0, 1, 2'b01); add(0, 0, 2'b01); add(0, 1, 2'b10); add(0, 0, 2'b10);
    add(1, 0, 2'b00);
    for (int k = 0; k < 10; k++) add(0, 1, (k % 2 == 0) ? 2'b01 : 2'b10);
    add(1, 0, 2'b00);
    add(0, 1, 2'b01); add(0, 1, 2'b10); add(0, 1, 2'b01); add(1, 1, 2'b00); add(0, 0, 2'b10);
`endif
    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].in);
      check($sformatf("vec%0d", k), out, vecs[k].exp);
    end
    step(1, 0);
    check("reset_before_random", out, 2'b00);
    ref_idle = 1'b1; ref_par = 1'b0; cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      r = ($urandom_range(0, 49) == 0);
      i = 1'($urandom_range(0, 1));
      if (r) begin
        ref_idle = 1'b1; ref_par = 1'b0; cnt = 0;
      end else begin
`ifdef SPD_FRAME_EN
        start = (cnt == 0);
        cnt = (cnt == FL - 1) ? 0 : cnt + 1;
`else
        start = 1'b0;
`endif
        ref_par = (ref_idle || start) ? i : ref_par ^ i;
        ref_idle = 1'b0;
      end
      e = ref_idle ? 2'b00 : (ref_par ? 2'b01 : 2'b10);
      step(r, i);
      check($sformatf("rand%0d", k), out, e);
      if (out == 2'b11) begin
        checks++;
        failures++;
        $display("FAIL rand_code11_%0d: out=%b required not 11", k, out);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
